// File: rtl/rv32_core_datapath.sv
// rv32_core_datapath: single-cycle RV32I integer datapath.
// Decode, 32x32 register file, ALU, load/store interface and PC sequencing.
// Instruction and data memories are external and answer combinationally;
// every instruction commits on one rising edge of i_clk.
// There are no valid/ready handshakes: every cycle carries exactly one
// instruction, and o_write/o_load qualify the data port for that cycle only.
// Optional debug load/observe ports are enabled by defining RV32_DEBUG_LOAD_EN.
module rv32_core_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_inst,
  input  logic [31:0]   i_mem,
  output logic [31:0]   o_pc,
  output logic [31:0]   o_addr,
  output logic [31:0]   o_mem,
  output logic          o_write,
  output logic          o_load,
  output logic [1:0]    o_memsize
`ifdef RV32_DEBUG_LOAD_EN
  ,
  input  logic [31:0]   i_pc,
  input  logic          i_pcload,
  input  logic          i_dload,
  input  logic [4:0]    i_daddr,
  input  logic [31:0]   i_ddata,
  output logic [1023:0] o_reg
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [31:0] r_pc;
  logic [31:0] r_regs [32];

  // Instruction fields and immediates
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val, w_pc_plus4;

  assign w_opcode   = i_inst[6:0];
  assign w_rd       = i_inst[11:7];
  assign w_f3       = i_inst[14:12];
  assign w_rs1      = i_inst[19:15];
  assign w_rs2      = i_inst[24:20];
  assign w_imm_i    = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s    = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b    = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u    = {i_inst[31:12], 12'b0};
  assign w_imm_j    = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  // Reads return the pre-edge value, so rd == rs1/rs2 needs no special case.
  assign w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
  assign w_pc_plus4 = r_pc + 32'd4;

  // ALU operand and operation selection per opcode
  logic [31:0] w_alu_a, w_alu_b;
  logic [2:0]  w_alu_f3;
  logic        w_alu_alt;
  always_comb begin
    w_alu_a   = w_rs1_val;
    w_alu_b   = w_imm_i;
    w_alu_f3  = 3'b000;
    w_alu_alt = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_alu_b   = w_rs2_val;
        w_alu_f3  = w_f3;
        w_alu_alt = i_inst[30];
      end
      OPC_OP_IMM: begin
        w_alu_f3  = w_f3;
        w_alu_alt = (w_f3 == 3'b101) && i_inst[30];
      end
      OPC_STORE: w_alu_b = w_imm_s;
      OPC_LUI: begin
        w_alu_a = 32'd0;
        w_alu_b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_alu_a = r_pc;
        w_alu_b = w_imm_u;
      end
      default: ;
    endcase
  end

  // ALU: funct3 picks the operation, alt selects SUB/SRA
  logic [31:0] w_alu_res;
  always_comb begin
    w_alu_res = 32'd0;
    case (w_alu_f3)
      3'b000: w_alu_res = w_alu_alt ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);
      3'b001: w_alu_res = w_alu_a << w_alu_b[4:0];
      3'b010: w_alu_res = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      3'b011: w_alu_res = {31'd0, w_alu_a < w_alu_b};
      3'b100: w_alu_res = w_alu_a ^ w_alu_b;
      3'b101: w_alu_res = w_alu_alt ? 32'($signed(w_alu_a) >>> w_alu_b[4:0])
                                    : (w_alu_a >> w_alu_b[4:0]);
      3'b110: w_alu_res = w_alu_a | w_alu_b;
      default: w_alu_res = w_alu_a & w_alu_b;
    endcase
  end

  // Load data extension by funct3
  logic [31:0] w_load_val;
  always_comb begin
    case (w_f3)
      3'b000:  w_load_val = {{24{i_mem[7]}}, i_mem[7:0]};
      3'b001:  w_load_val = {{16{i_mem[15]}}, i_mem[15:0]};
      3'b010:  w_load_val = i_mem;
      3'b100:  w_load_val = {24'd0, i_mem[7:0]};
      3'b101:  w_load_val = {16'd0, i_mem[15:0]};
      default: w_load_val = 32'd0;
    endcase
  end

  // Branch condition evaluation
  logic w_taken;
  always_comb begin
    case (w_f3)
      3'b000:  w_taken = (w_rs1_val == w_rs2_val);
      3'b001:  w_taken = (w_rs1_val != w_rs2_val);
      3'b100:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110:  w_taken = (w_rs1_val <  w_rs2_val);
      3'b111:  w_taken = (w_rs1_val >= w_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  // Write-back, next-PC and memory-control selection; unknown opcodes are NOPs
  logic        w_we;
  logic [31:0] w_wdata, w_next_pc;
  logic [1:0]  w_memsize;
  logic        w_load;
  always_comb begin
    w_we      = 1'b0;
    w_wdata   = w_alu_res;
    w_next_pc = w_pc_plus4;
    w_memsize = 2'b00;
    w_load    = 1'b0;
    case (w_opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: w_we = 1'b1;
      OPC_JAL: begin
        w_we      = 1'b1;
        w_wdata   = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      OPC_JALR: begin
        w_we      = 1'b1;
        w_wdata   = w_pc_plus4;
        w_next_pc = w_alu_res & ~32'd1;
      end
      OPC_BRANCH: if (w_taken) w_next_pc = r_pc + w_imm_b;
      OPC_LOAD: begin
        w_we    = 1'b1;
        w_wdata = w_load_val;
        w_load  = 1'b1;
      end
      OPC_STORE: begin
        case (w_f3)
          3'b000:  w_memsize = 2'b01;
          3'b001:  w_memsize = 2'b10;
          3'b010:  w_memsize = 2'b11;
          default: w_memsize = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign o_pc      = r_pc;
  assign o_addr    = w_alu_res;
  assign o_mem     = w_rs2_val;
  assign o_memsize = w_memsize;
  assign o_write   = (w_memsize != 2'b00);
  assign o_load    = w_load;

  // Commit PC and register write; a debug load wins over the instruction write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
`ifdef RV32_DEBUG_LOAD_EN
      r_pc <= i_pcload ? i_pc : w_next_pc;
`else
      r_pc <= w_next_pc;
`endif
      if (w_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_wdata;
`ifdef RV32_DEBUG_LOAD_EN
      if (i_dload && (i_daddr != 5'd0)) r_regs[i_daddr] <= i_ddata;
`endif
    end
  end

`ifdef RV32_DEBUG_LOAD_EN
  // Flatten the register file for observation
  always_comb begin
    for (int n = 0; n < 32; n++) o_reg[32*n +: 32] = r_regs[n];
  end
`endif

endmodule

// File: tb/tb_rv32_core_datapath.sv
// tb_rv32_core_datapath: directed-vector bench for rv32_core_datapath.
// Register contents are observed through store/ALU operands (o_mem, o_addr).
module tb_rv32_core_datapath;

  localparam logic [6:0] OPI = 7'h13, LD = 7'h03, JR = 7'h67, LU = 7'h37, AUI = 7'h17;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_inst = 32'd0;
  logic [31:0] i_mem = 32'd0;
  logic [31:0] o_pc, o_addr, o_mem;
  logic        o_write, o_load;
  logic [1:0]  o_memsize;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  rv32_core_datapath dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_inst    (i_inst),
    .i_mem     (i_mem),
    .o_pc      (o_pc),
    .o_addr    (o_addr),
    .o_mem     (o_mem),
    .o_write   (o_write),
    .o_load    (o_load),
    .o_memsize (o_memsize)
  );

  // Instruction encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // Driver: present one instruction after the falling edge; it commits at the next rising edge
  task automatic drive(input logic [31:0] inst, input logic [31:0] mem);
    @(negedge clk);
    i_inst = inst;
    i_mem  = mem;
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    i_inst = enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, OPI);
    #12;
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", o_pc, 32'h0); end
    checks++; if (o_write !== 1'b0 || o_load !== 1'b0 || o_memsize !== 2'b00) begin
      errors++; $display("FAIL reset_memctl got=%b%b%b exp=000", o_write, o_load, o_memsize); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_addi_lui_auipc();
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL addi_pc got=%h exp=%h", o_pc, 32'h0); end
    checks++; if (o_addr !== 32'hFFFF_FFFB) begin errors++; $display("FAIL addi_res got=%h exp=%h", o_addr, 32'hFFFF_FFFB); end
    drive(enc_u(20'h12345, 5'd2, LU), 32'd0);
    checks++; if (o_pc !== 32'h4) begin errors++; $display("FAIL lui_pc got=%h exp=%h", o_pc, 32'h4); end
    checks++; if (o_addr !== 32'h1234_5000) begin errors++; $display("FAIL lui_res got=%h exp=%h", o_addr, 32'h1234_5000); end
    drive(enc_u(20'h00001, 5'd3, AUI), 32'd0);
    checks++; if (o_addr !== 32'h0000_1008) begin errors++; $display("FAIL auipc_res got=%h exp=%h", o_addr, 32'h0000_1008); end
    drive(enc_i(12'h007, 5'd0, 3'd0, 5'd0, OPI), 32'd0);
    checks++; if (o_pc !== 32'hC) begin errors++; $display("FAIL addi_x0_pc got=%h exp=%h", o_pc, 32'hC); end
    drive(enc_s(12'h000, 5'd2, 5'd1, 3'd2), 32'd0);
    checks++; if (o_addr !== 32'hFFFF_FFFB) begin errors++; $display("FAIL x1_read got=%h exp=%h", o_addr, 32'hFFFF_FFFB); end
    checks++; if (o_mem !== 32'h1234_5000) begin errors++; $display("FAIL x2_read got=%h exp=%h", o_mem, 32'h1234_5000); end
    checks++; if (o_write !== 1'b1 || o_memsize !== 2'b11) begin
      errors++; $display("FAIL sw_ctl got=%b/%b exp=1/11", o_write, o_memsize); end
    drive(enc_s(12'h000, 5'd0, 5'd3, 3'd2), 32'd0);
    checks++; if (o_addr !== 32'h0000_1008) begin errors++; $display("FAIL x3_read got=%h exp=%h", o_addr, 32'h0000_1008); end
    checks++; if (o_mem !== 32'h0) begin errors++; $display("FAIL x0_read got=%h exp=%h", o_mem, 32'h0); end
  endtask

  task automatic test_branch();
    drive(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OPI), 32'd0);
    drive(enc_i(12'h001, 5'd0, 3'd0, 5'd2, OPI), 32'd0);
    drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd4), 32'd0);          // BLT taken
    checks++; if (o_pc !== 32'h20) begin errors++; $display("FAIL blt_at got=%h exp=%h", o_pc, 32'h20); end
    checks++; if (o_write !== 1'b0 || o_memsize !== 2'b00) begin
      errors++; $display("FAIL branch_memctl got=%b/%b exp=0/00", o_write, o_memsize); end
    drive(enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0), 32'd0);          // BEQ -8 taken
    checks++; if (o_pc !== 32'h30) begin errors++; $display("FAIL blt_target got=%h exp=%h", o_pc, 32'h30); end
    drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd6), 32'd0);          // BLTU not taken
    checks++; if (o_pc !== 32'h28) begin errors++; $display("FAIL beq_target got=%h exp=%h", o_pc, 32'h28); end
    drive(enc_b(13'h0040, 5'd2, 5'd1, 3'd5), 32'd0);          // BGE not taken
    checks++; if (o_pc !== 32'h2C) begin errors++; $display("FAIL bltu_fallthru got=%h exp=%h", o_pc, 32'h2C); end
    drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd7), 32'd0);          // BGEU taken
    checks++; if (o_pc !== 32'h30) begin errors++; $display("FAIL bge_fallthru got=%h exp=%h", o_pc, 32'h30); end
  endtask

  task automatic test_jump();
    drive(enc_j(21'h000100, 5'd1), 32'd0);                    // JAL x1,+0x100
    checks++; if (o_pc !== 32'h40) begin errors++; $display("FAIL bgeu_target got=%h exp=%h", o_pc, 32'h40); end
    drive(enc_i(12'h003, 5'd1, 3'd0, 5'd5, JR), 32'd0);       // JALR x5,x1,3
    checks++; if (o_pc !== 32'h140) begin errors++; $display("FAIL jal_target got=%h exp=%h", o_pc, 32'h140); end
    checks++; if (o_addr !== 32'h47) begin errors++; $display("FAIL jalr_sum got=%h exp=%h", o_addr, 32'h47); end
    drive(enc_i(12'h010, 5'd1, 3'd0, 5'd1, JR), 32'd0);       // JALR x1,x1,16 (rd == rs1)
    checks++; if (o_pc !== 32'h46) begin errors++; $display("FAIL jalr_target got=%h exp=%h", o_pc, 32'h46); end
    checks++; if (o_addr !== 32'h54) begin errors++; $display("FAIL jalr_rd_eq_rs1 got=%h exp=%h", o_addr, 32'h54); end
    drive(enc_s(12'h000, 5'd5, 5'd1, 3'd2), 32'd0);
    checks++; if (o_pc !== 32'h54) begin errors++; $display("FAIL jalr2_target got=%h exp=%h", o_pc, 32'h54); end
    checks++; if (o_mem !== 32'h144) begin errors++; $display("FAIL jalr_link got=%h exp=%h", o_mem, 32'h144); end
    checks++; if (o_addr !== 32'h4A) begin errors++; $display("FAIL jalr2_link got=%h exp=%h", o_addr, 32'h4A); end
  endtask

  task automatic test_load();
    drive(enc_u(20'h00001, 5'd4, LU), 32'd0);                 // x4 = 0x1000
    drive(enc_i(12'h001, 5'd4, 3'd0, 5'd6, LD), 32'h0000_0080); // LB
    checks++; if (o_load !== 1'b1 || o_write !== 1'b0 || o_memsize !== 2'b00) begin
      errors++; $display("FAIL lb_ctl got=%b%b%b exp=1000", o_load, o_write, o_memsize); end
    checks++; if (o_addr !== 32'h1001) begin errors++; $display("FAIL lb_addr got=%h exp=%h", o_addr, 32'h1001); end
    drive(enc_i(12'h001, 5'd4, 3'd4, 5'd7, LD), 32'h0000_0080); // LBU
    drive(enc_s(12'h000, 5'd6, 5'd7, 3'd2), 32'd0);
    checks++; if (o_mem !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_val got=%h exp=%h", o_mem, 32'hFFFF_FF80); end
    checks++; if (o_addr !== 32'h80) begin errors++; $display("FAIL lbu_val got=%h exp=%h", o_addr, 32'h80); end
    checks++; if (o_load !== 1'b0) begin errors++; $display("FAIL store_noload got=%b exp=0", o_load); end
    drive(enc_i(12'h000, 5'd4, 3'd1, 5'd8, LD), 32'h0000_8001); // LH
    drive(enc_i(12'h000, 5'd4, 3'd2, 5'd9, LD), 32'hCAFE_F00D); // LW
    drive(enc_s(12'h000, 5'd8, 5'd9, 3'd2), 32'd0);
    checks++; if (o_mem !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_val got=%h exp=%h", o_mem, 32'hFFFF_8001); end
    checks++; if (o_addr !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw_val got=%h exp=%h", o_addr, 32'hCAFE_F00D); end
    drive(enc_i(12'h000, 5'd4, 3'd5, 5'd8, LD), 32'h0001_8001); // LHU
    drive(enc_s(12'h000, 5'd8, 5'd0, 3'd2), 32'd0);
    checks++; if (o_mem !== 32'h0000_8001) begin errors++; $display("FAIL lhu_val got=%h exp=%h", o_mem, 32'h0000_8001); end
    drive(enc_i(12'h000, 5'd4, 3'd3, 5'd8, LD), 32'hFFFF_FFFF); // reserved funct3
    drive(enc_s(12'h000, 5'd8, 5'd0, 3'd2), 32'd0);
    checks++; if (o_mem !== 32'h0) begin errors++; $display("FAIL ld_bad_f3 got=%h exp=%h", o_mem, 32'h0); end
    checks++; if (o_pc !== 32'h80) begin errors++; $display("FAIL load_seq_pc got=%h exp=%h", o_pc, 32'h80); end
  endtask

  task automatic test_store();
    drive(enc_u(20'hDEADC, 5'd7, LU), 32'd0);
    drive(enc_i(12'hEEF, 5'd7, 3'd0, 5'd7, OPI), 32'd0);      // x7 = 0xDEADBEEF
    drive(enc_s(12'h002, 5'd7, 5'd4, 3'd1), 32'd0);           // SH x7,2(x4)
    checks++; if (o_write !== 1'b1 || o_memsize !== 2'b10 || o_load !== 1'b0) begin
      errors++; $display("FAIL sh_ctl got=%b/%b/%b exp=1/10/0", o_write, o_memsize, o_load); end
    checks++; if (o_addr !== 32'h1002) begin errors++; $display("FAIL sh_addr got=%h exp=%h", o_addr, 32'h1002); end
    checks++; if (o_mem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sh_data got=%h exp=%h", o_mem, 32'hDEAD_BEEF); end
    drive(enc_s(12'h003, 5'd7, 5'd4, 3'd0), 32'd0);           // SB
    checks++; if (o_memsize !== 2'b01 || o_addr !== 32'h1003) begin
      errors++; $display("FAIL sb got=%b/%h exp=01/00001003", o_memsize, o_addr); end
    drive(enc_s(12'h000, 5'd7, 5'd4, 3'd3), 32'd0);           // reserved store funct3
    checks++; if (o_write !== 1'b0 || o_memsize !== 2'b00) begin
      errors++; $display("FAIL st_bad_f3 got=%b/%b exp=0/00", o_write, o_memsize); end
    drive(enc_s(12'h000, 5'd7, 5'd4, 3'd2), 32'd0);
    checks++; if (o_addr !== 32'h1000) begin errors++; $display("FAIL store_nowrite got=%h exp=%h", o_addr, 32'h1000); end
  endtask

  task automatic test_alu();
    // x1=0x4A, x2=1, x5=0x144, x7=0xDEADBEEF
    drive(enc_r(7'h20, 5'd5, 5'd1, 3'd0, 5'd10), 32'd0);
    checks++; if (o_addr !== 32'hFFFF_FF06) begin errors++; $display("FAIL sub got=%h exp=%h", o_addr, 32'hFFFF_FF06); end
    drive(enc_r(7'h20, 5'd2, 5'd7, 3'd5, 5'd11), 32'd0);
    checks++; if (o_addr !== 32'hEF56_DF77) begin errors++; $display("FAIL sra got=%h exp=%h", o_addr, 32'hEF56_DF77); end
    drive(enc_r(7'h00, 5'd2, 5'd7, 3'd5, 5'd12), 32'd0);
    checks++; if (o_addr !== 32'h6F56_DF77) begin errors++; $display("FAIL srl got=%h exp=%h", o_addr, 32'h6F56_DF77); end
    drive(enc_r(7'h00, 5'd7, 5'd1, 3'd3, 5'd13), 32'd0);
    checks++; if (o_addr !== 32'h1) begin errors++; $display("FAIL sltu got=%h exp=%h", o_addr, 32'h1); end
    drive(enc_r(7'h00, 5'd7, 5'd1, 3'd2, 5'd14), 32'd0);
    checks++; if (o_addr !== 32'h0) begin errors++; $display("FAIL slt got=%h exp=%h", o_addr, 32'h0); end
    drive(enc_i(12'h404, 5'd7, 3'd5, 5'd15, OPI), 32'd0);
    checks++; if (o_addr !== 32'hFDEA_DBEE) begin errors++; $display("FAIL srai got=%h exp=%h", o_addr, 32'hFDEA_DBEE); end
    drive(enc_i(12'h004, 5'd7, 3'd1, 5'd16, OPI), 32'd0);
    checks++; if (o_addr !== 32'hEADB_EEF0) begin errors++; $display("FAIL slli got=%h exp=%h", o_addr, 32'hEADB_EEF0); end
    drive(enc_i(12'hFFF, 5'd7, 3'd4, 5'd17, OPI), 32'd0);
    checks++; if (o_addr !== 32'h2152_4110) begin errors++; $display("FAIL xori got=%h exp=%h", o_addr, 32'h2152_4110); end
    drive(enc_i(12'h0FF, 5'd7, 3'd7, 5'd18, OPI), 32'd0);
    checks++; if (o_addr !== 32'hEF) begin errors++; $display("FAIL andi got=%h exp=%h", o_addr, 32'hEF); end
    drive(enc_r(7'h00, 5'd5, 5'd1, 3'd6, 5'd19), 32'd0);
    checks++; if (o_addr !== 32'h14E) begin errors++; $display("FAIL or got=%h exp=%h", o_addr, 32'h14E); end
    drive(enc_b(13'h0008, 5'd2, 5'd1, 3'd1), 32'd0);          // BNE taken, at 0xC4
    checks++; if (o_pc !== 32'hC4) begin errors++; $display("FAIL bne_at got=%h exp=%h", o_pc, 32'hC4); end
    drive(enc_r(7'h00, 5'd5, 5'd1, 3'd7, 5'd20), 32'd0);
    checks++; if (o_pc !== 32'hCC) begin errors++; $display("FAIL bne_target got=%h exp=%h", o_pc, 32'hCC); end
    checks++; if (o_addr !== 32'h40) begin errors++; $display("FAIL and got=%h exp=%h", o_addr, 32'h40); end
    drive(enc_s(12'h000, 5'd11, 5'd13, 3'd2), 32'd0);
    checks++; if (o_mem !== 32'hEF56_DF77 || o_addr !== 32'h1) begin
      errors++; $display("FAIL alu_writeback got=%h/%h exp=ef56df77/00000001", o_mem, o_addr); end
  endtask

  task automatic test_reset_midcycle();
    drive(enc_s(12'h000, 5'd7, 5'd4, 3'd2), 32'd0);
    checks++; if (o_pc !== 32'hD4 || o_mem !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL pre_reset got=%h/%h exp=000000d4/deadbeef", o_pc, o_mem); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc got=%h exp=%h", o_pc, 32'h0); end
    checks++; if (o_mem !== 32'h0 || o_addr !== 32'h0) begin
      errors++; $display("FAIL async_reset_regs got=%h/%h exp=0/0", o_mem, o_addr); end
    i_inst = enc_s(12'h000, 5'd5, 5'd1, 3'd2);
    #1;
    checks++; if (o_mem !== 32'h0 || o_addr !== 32'h0) begin
      errors++; $display("FAIL reset_regs2 got=%h/%h exp=0/0", o_mem, o_addr); end
    i_inst = enc_i(12'h001, 5'd0, 3'd0, 5'd1, OPI);
    @(posedge clk);
    #1;
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_hold_pc got=%h exp=%h", o_pc, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    drive(enc_s(12'h000, 5'd1, 5'd0, 3'd2), 32'd0);
    checks++; if (o_pc !== 32'h4 || o_mem !== 32'h1) begin
      errors++; $display("FAIL post_reset got=%h/%h exp=00000004/00000001", o_pc, o_mem); end
  endtask

  // Sequence the scenarios and report
  initial begin
    test_reset();
    test_addi_lui_auipc();
    test_branch();
    test_jump();
    test_load();
    test_store();
    test_alu();
    test_reset_midcycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
